seven_segment_scanner: RTL

- Multiplexed-display scanner directly upstream of the per-segment seven-segment decoders.
- Holds a packed multi-digit hex value and time-multiplexes one 4-bit nibble at a time onto the shared `encoded` bus that feeds all segment decoders.
- Drives a one-hot digit enable and inserts blanking gaps between digits to suppress ghosting.
- New values are accepted through a valid/ready handshake and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_segment_scanner.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/seven_segment_scanner.sv
// rtl/seven_segment_scanner.sv - multiplexed hex display scanner with framed valid/ready loading
//
// Purpose:
//   Time-multiplexes a packed DIGITS-nibble value onto one shared 4-bit bus
//   that feeds the segment decoders. Each digit gets a slot of BLANK_CYCLES
//   dark cycles followed by PRESCALE lit cycles. New values are taken through
//   a one-deep pending buffer and copied into the display register only when
//   the digit index wraps, so a frame never mixes old and new digits.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   load_valid    in   load_data offered this cycle
//   load_data     in   packed value, digit 0 in bits [3:0]
//   load_ready    out  pending buffer empty (state-only)
//   blank_leading in   suppress enables of leading zero digits
//   encoded       out  nibble of the selected digit (registered)
//   digit_enable  out  one-hot lit digit, zero while blanking (registered)
//   frame_done    out  one-cycle pulse after each index wrap (registered)

module seven_segment_scanner #(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  input  logic                  blank_leading,
  output logic [3:0]            encoded,
  output logic [DIGITS-1:0]     digit_enable,
  output logic                  frame_done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC  = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_cnt;
  logic [4*DIGITS-1:0]   r_display;
  logic [4*DIGITS-1:0]   r_pending;
  logic                  r_pending_valid;
  logic [3:0]            r_encoded;
  logic [DIGITS-1:0]     r_digit_enable;
  logic                  r_frame_done;

  state_t                w_state_nxt;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_wrap;
  logic [4*DIGITS-1:0]   w_display_nxt;
  logic [3:0]            w_nibble_nxt;
  logic [DIGITS-1:0]     w_enable_nxt;

  // Digit i is a leading zero when it and every digit above it are zero.
  // Digit 0 always stays lit so a zero value still shows "0".
  function automatic logic is_leading_zero(input logic [4*DIGITS-1:0] v,
                                           input logic [IDX_W-1:0]    i);
    logic zero_above;
    zero_above = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(i) && v[4*k +: 4] != 4'h0) begin
        zero_above = 1'b0;
      end
    end
    return (i != '0) && zero_above;
  endfunction

  // Next-state view of the scan. Outputs are registered from these values so
  // that they line up with the state they describe instead of lagging by one.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_wrap      = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
        end
      end
      ST_SHOW: begin
        if (r_cnt == SHOW_LAST) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_wrap    = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase

    // Pending value becomes visible exactly at the frame boundary.
    w_display_nxt = (w_wrap && r_pending_valid) ? r_pending : r_display;
    w_nibble_nxt  = w_display_nxt[{w_idx_nxt, 2'b00} +: 4];

    w_enable_nxt = '0;
    if (w_state_nxt == ST_SHOW &&
        !(blank_leading && is_leading_zero(w_display_nxt, w_idx_nxt))) begin
      w_enable_nxt = DIGITS'(1) << w_idx_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_BLANK;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_display       <= '0;
      r_pending       <= '0;
      r_pending_valid <= 1'b0;
      r_encoded       <= 4'h0;
      r_digit_enable  <= '0;
      r_frame_done    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_idx          <= w_idx_nxt;
      r_cnt          <= w_cnt_nxt;
      r_display      <= w_display_nxt;
      r_encoded      <= w_nibble_nxt;
      r_digit_enable <= w_enable_nxt;
      r_frame_done   <= w_wrap;

      // The two branches are exclusive: a load is only accepted into an empty
      // buffer, so a load taken on the wrap edge waits for the next wrap.
      if (w_wrap && r_pending_valid) begin
        r_pending_valid <= 1'b0;
      end else if (load_valid && !r_pending_valid) begin
        r_pending       <= load_data;
        r_pending_valid <= 1'b1;
      end
    end
  end

  assign load_ready   = !r_pending_valid;
  assign encoded      = r_encoded;
  assign digit_enable = r_digit_enable;
  assign frame_done   = r_frame_done;

endmodule
